// File: rtl/mmu_pkg.sv
// Shared types and constants for the address-translation stage:
// exception codes, DMW field layout and the supported page sizes.
package mmu_pkg;

    typedef enum logic [2:0] {
        ECODE_NONE = 3'd0,
        ECODE_TLBR = 3'd1,
        ECODE_PIL  = 3'd2,
        ECODE_PIS  = 3'd3,
        ECODE_PIF  = 3'd4,
        ECODE_PPI  = 3'd5,
        ECODE_PME  = 3'd6
    } ecode_t;

    localparam int DMW_PLV0_BIT = 0;
    localparam int DMW_PLV3_BIT = 3;
    localparam int DMW_MAT_LSB  = 4;
    localparam int DMW_PSEG_LSB = 25;
    localparam int DMW_VSEG_LSB = 29;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    // Replace the low page-offset bits of the page base with the virtual offset.
    function automatic logic [31:0] page_paddr(input logic [19:0] ppn,
                                               input logic [31:0] vaddr,
                                               input logic [5:0]  ps);
        logic [31:0] mask;
        mask = (ps == PS_4K) ? ((32'h1 << PS_4K) - 32'h1) : ((32'h1 << PS_2M) - 32'h1);
        return ({ppn, 12'h000} & ~mask) | (vaddr & mask);
    endfunction

endpackage

// File: rtl/mmu_dmw_match.sv
// Single direct-mapped window check: segment compare, privilege enable,
// and the resulting physical address and MAT.
module mmu_dmw_match
    import mmu_pkg::*;
(
    input  logic [31:0] i_dmw,
    input  logic [31:0] i_vaddr,
    input  logic [1:0]  i_plv,
    output logic        o_hit,
    output logic [31:0] o_paddr,
    output logic [1:0]  o_mat
);

    logic w_plv_ok;
    logic w_dmw_unused;

    // Only PLV0 and PLV3 have enable bits; PLV1/2 never match a window.
    assign w_plv_ok = ((i_plv == 2'd0) && i_dmw[DMW_PLV0_BIT]) ||
                      ((i_plv == 2'd3) && i_dmw[DMW_PLV3_BIT]);
    assign o_hit    = (i_vaddr[31:29] == i_dmw[DMW_VSEG_LSB +: 3]) && w_plv_ok;
    assign o_paddr  = {i_dmw[DMW_PSEG_LSB +: 3], i_vaddr[28:0]};
    assign o_mat    = i_dmw[DMW_MAT_LSB +: 2];

    assign w_dmw_unused = ^{i_dmw[28], i_dmw[24:6], i_dmw[2:1]};

endmodule

// File: rtl/mmu_xlate.sv
// Two-stage translation: stage 1 launches the TLB search and decides mode/DMW,
// stage 2 merges the registered TLB result into paddr, MAT and exception code.
module mmu_xlate
    import mmu_pkg::*;
#(
    parameter int PALEN     = 32,
    parameter int TLB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_vaddr,
    input  logic                 req_fetch,
    input  logic                 req_store,
    input  logic [9:0]           csr_asid,
    input  logic [1:0]           csr_plv,
    input  logic                 csr_da,
    input  logic                 csr_pg,
    input  logic [1:0]           csr_datm,
    input  logic [31:0]          csr_dmw0,
    input  logic [31:0]          csr_dmw1,
    output logic                 s_fetch,
    output logic [18:0]          s_vppn,
    output logic                 s_odd_page,
    output logic [9:0]           s_asid,
    input  logic                 s_found,
    input  logic [TLB_IDX_W-1:0] s_index,
    input  logic [5:0]           s_ps,
    input  logic [19:0]          s_ppn,
    input  logic                 s_v,
    input  logic                 s_d,
    input  logic [1:0]           s_mat,
    input  logic [1:0]           s_plv,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [PALEN-1:0]     resp_paddr,
    output logic [1:0]           resp_mat,
    output ecode_t               resp_ecode,
    output logic [31:0]          resp_badv,
    output logic [TLB_IDX_W-1:0] resp_tlb_idx
);

    logic        w_accept;
    logic [31:0] w_dmw      [2];
    logic        w_dmw_hit  [2];
    logic [31:0] w_dmw_pa   [2];
    logic [1:0]  w_dmw_mat  [2];

    logic        r_valid;
    logic [31:0] r_vaddr;
    logic        r_fetch;
    logic        r_store;
    logic [1:0]  r_plv;
    logic        r_direct;
    logic        r_dmw_hit;
    logic [31:0] r_dmw_paddr;
    logic [1:0]  r_dmw_mat;
    logic [1:0]  r_datm;

    ecode_t      w_ecode;
    logic [31:0] w_paddr;
    logic [1:0]  w_mat;
    logic        w_tlb_path;

    assign req_ready  = !r_valid || resp_ready;
    assign w_accept   = req_valid && req_ready && !flush;
    // Searching only on accept keeps the TLB result registers frozen during a stall.
    assign s_fetch    = w_accept;
    assign s_vppn     = req_vaddr[31:13];
    assign s_odd_page = req_vaddr[12];
    assign s_asid     = csr_asid;

    assign w_dmw[0] = csr_dmw0;
    assign w_dmw[1] = csr_dmw1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dmw
            mmu_dmw_match u_match (
                .i_dmw   (w_dmw[gi]),
                .i_vaddr (req_vaddr),
                .i_plv   (csr_plv),
                .o_hit   (w_dmw_hit[gi]),
                .o_paddr (w_dmw_pa[gi]),
                .o_mat   (w_dmw_mat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_vaddr     <= '0;
            r_fetch     <= 1'b0;
            r_store     <= 1'b0;
            r_plv       <= '0;
            r_direct    <= 1'b0;
            r_dmw_hit   <= 1'b0;
            r_dmw_paddr <= '0;
            r_dmw_mat   <= '0;
            r_datm      <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (resp_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_vaddr     <= req_vaddr;
                r_fetch     <= req_fetch;
                r_store     <= req_store && !req_fetch;
                r_plv       <= csr_plv;
                r_direct    <= csr_da && !csr_pg;
                r_dmw_hit   <= w_dmw_hit[0] || w_dmw_hit[1];
                r_dmw_paddr <= w_dmw_hit[0] ? w_dmw_pa[0]  : w_dmw_pa[1];
                r_dmw_mat   <= w_dmw_hit[0] ? w_dmw_mat[0] : w_dmw_mat[1];
                r_datm      <= csr_datm;
            end
        end
    end

    always_comb begin
        w_ecode    = ECODE_NONE;
        w_paddr    = r_vaddr;
        w_mat      = r_datm;
        w_tlb_path = 1'b0;
        if (r_direct) begin
            w_paddr = r_vaddr;
            w_mat   = r_datm;
        end else if (r_dmw_hit) begin
            w_paddr = r_dmw_paddr;
            w_mat   = r_dmw_mat;
        end else begin
            w_tlb_path = 1'b1;
            w_paddr    = page_paddr(s_ppn, r_vaddr, s_ps);
            w_mat      = s_mat;
            if (!s_found) begin
                w_ecode = ECODE_TLBR;
            end else if (!s_v) begin
                w_ecode = r_fetch ? ECODE_PIF : (r_store ? ECODE_PIS : ECODE_PIL);
            end else if (r_plv > s_plv) begin
                w_ecode = ECODE_PPI;
            end else if (r_store && !s_d) begin
                w_ecode = ECODE_PME;
            end
        end
    end

    assign resp_valid   = r_valid;
    assign resp_paddr   = r_valid ? PALEN'(w_paddr) : '0;
    assign resp_mat     = r_valid ? w_mat : 2'd0;
    assign resp_ecode   = r_valid ? w_ecode : ECODE_NONE;
    assign resp_badv    = (r_valid && (w_ecode != ECODE_NONE)) ? r_vaddr : 32'd0;
    assign resp_tlb_idx = (r_valid && w_tlb_path) ? s_index : '0;

endmodule

// File: tb/tb_mmu_xlate.sv
// Directed bench for mmu_xlate: direct, DMW and TLB paths, exception priority,
// page sizes, stall stability, flush and reset during a stall.
module tb_mmu_xlate;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_fetch;
    logic        req_store;
    logic [9:0]  csr_asid;
    logic [1:0]  csr_plv;
    logic        csr_da;
    logic        csr_pg;
    logic [1:0]  csr_datm;
    logic [31:0] csr_dmw0;
    logic [31:0] csr_dmw1;
    logic        s_fetch;
    logic [18:0] s_vppn;
    logic        s_odd_page;
    logic [9:0]  s_asid;
    logic        s_found;
    logic [4:0]  s_index;
    logic [5:0]  s_ps;
    logic [19:0] s_ppn;
    logic        s_v;
    logic        s_d;
    logic [1:0]  s_mat;
    logic [1:0]  s_plv;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_paddr;
    logic [1:0]  resp_mat;
    logic [2:0]  resp_ecode;
    logic [31:0] resp_badv;
    logic [4:0]  resp_tlb_idx;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] EC_NONE = 3'd0, EC_TLBR = 3'd1, EC_PIL = 3'd2, EC_PIS = 3'd3,
                           EC_PIF = 3'd4, EC_PPI = 3'd5, EC_PME = 3'd6;

    mmu_xlate #(.PALEN(32), .TLB_IDX_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_fetch(req_fetch), .req_store(req_store),
        .csr_asid(csr_asid), .csr_plv(csr_plv), .csr_da(csr_da), .csr_pg(csr_pg),
        .csr_datm(csr_datm), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
        .s_fetch(s_fetch), .s_vppn(s_vppn), .s_odd_page(s_odd_page), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .s_ps(s_ps), .s_ppn(s_ppn),
        .s_v(s_v), .s_d(s_d), .s_mat(s_mat), .s_plv(s_plv),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_mat(resp_mat), .resp_ecode(resp_ecode), .resp_badv(resp_badv),
        .resp_tlb_idx(resp_tlb_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request with resp_ready high; response checked one cycle after accept.
    task automatic xact(input string name, input logic [31:0] va, input logic f, input logic st,
                        input logic [31:0] pa, input logic [1:0] mat, input logic [2:0] ec,
                        input logic [4:0] idx);
        logic [31:0] exp_badv;
        logic [18:0] exp_vppn;
        exp_badv = (ec != EC_NONE) ? va : 32'd0;
        exp_vppn = va[31:13];
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = va;
        req_fetch = f;
        req_store = st;
        #1;
        check({name, "/s_fetch"}, 32'(s_fetch), 32'd1);
        check({name, "/s_vppn"}, 32'(s_vppn), 32'(exp_vppn));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({name, "/valid"}, 32'(resp_valid), 32'd1);
        check({name, "/paddr"}, resp_paddr, pa);
        check({name, "/mat"}, 32'(resp_mat), 32'(mat));
        check({name, "/ecode"}, 32'(resp_ecode), 32'(ec));
        check({name, "/badv"}, resp_badv, exp_badv);
        check({name, "/idx"}, 32'(resp_tlb_idx), 32'(idx));
        $display("xact %-10s va=%08h pa=%08h mat=%0d ecode=%0d idx=%0d",
                 name, va, resp_paddr, resp_mat, resp_ecode, resp_tlb_idx);
    endtask

    task automatic tlb_set(input logic found, input logic [5:0] ps, input logic [19:0] ppn,
                           input logic v, input logic d, input logic [1:0] plv);
        s_found = found; s_ps = ps; s_ppn = ppn; s_v = v; s_d = d; s_plv = plv;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_fetch = 1'b0;
        req_store = 1'b0; csr_asid = 10'h155; csr_plv = 2'd0; csr_da = 1'b1; csr_pg = 1'b0;
        csr_datm = 2'd1; csr_dmw0 = '0; csr_dmw1 = '0; resp_ready = 1'b1;
        s_index = 5'd7; s_mat = 2'd2;
        tlb_set(1'b1, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd3);
        repeat (2) @(posedge clk);
        #1;
        check("reset/valid", 32'(resp_valid), 32'd0);
        check("reset/s_fetch", 32'(s_fetch), 32'd0);
        check("reset/paddr", resp_paddr, 32'd0);
        check("reset/ecode", 32'(resp_ecode), 32'(EC_NONE));
        check("reset/ready", 32'(req_ready), 32'd1);
        check("reset/asid", 32'(s_asid), 32'h155);
        rst = 1'b0;

        xact("direct", 32'h1C00_0100, 1'b1, 1'b0, 32'h1C00_0100, 2'd1, EC_NONE, 5'd0);

        csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0;
        csr_dmw0 = 32'hA000_0011;
        xact("dmw0", 32'hA000_1234, 1'b0, 1'b0, 32'h0000_1234, 2'd1, EC_NONE, 5'd0);
        csr_dmw1 = 32'hA600_0031;
        xact("dmw0prio", 32'hA000_1234, 1'b0, 1'b0, 32'h0000_1234, 2'd1, EC_NONE, 5'd0);
        csr_dmw0 = 32'h0;
        xact("dmw1", 32'hA000_1234, 1'b0, 1'b0, 32'h6000_1234, 2'd3, EC_NONE, 5'd0);
        csr_dmw0 = 32'hA000_0011; csr_plv = 2'd1;
        xact("dmwplv1", 32'hA000_1234, 1'b0, 1'b0, 32'h1234_5234, 2'd2, EC_NONE, 5'd7);
        csr_dmw1 = 32'h0; csr_plv = 2'd3;
        xact("dmwplv3", 32'hA000_1234, 1'b0, 1'b0, 32'h1234_5234, 2'd2, EC_NONE, 5'd7);

        xact("tlbload", 32'h0040_2ABC, 1'b0, 1'b0, 32'h1234_5ABC, 2'd2, EC_NONE, 5'd7);
        tlb_set(1'b1, 6'd12, 20'h12345, 1'b1, 1'b0, 2'd3);
        xact("pme", 32'h0040_2ABC, 1'b0, 1'b1, 32'h1234_5ABC, 2'd2, EC_PME, 5'd7);
        xact("fetchst", 32'h0040_2ABC, 1'b1, 1'b1, 32'h1234_5ABC, 2'd2, EC_NONE, 5'd7);
        tlb_set(1'b0, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd3);
        xact("tlbr", 32'h0040_2ABC, 1'b0, 1'b0, 32'h1234_5ABC, 2'd2, EC_TLBR, 5'd7);
        tlb_set(1'b1, 6'd12, 20'h12345, 1'b0, 1'b1, 2'd3);
        xact("pif", 32'h0040_2ABC, 1'b1, 1'b0, 32'h1234_5ABC, 2'd2, EC_PIF, 5'd7);
        xact("pis", 32'h0040_2ABC, 1'b0, 1'b1, 32'h1234_5ABC, 2'd2, EC_PIS, 5'd7);
        xact("pil", 32'h0040_2ABC, 1'b0, 1'b0, 32'h1234_5ABC, 2'd2, EC_PIL, 5'd7);
        tlb_set(1'b1, 6'd12, 20'h12345, 1'b1, 1'b0, 2'd0);
        xact("ppi", 32'h0040_2ABC, 1'b0, 1'b1, 32'h1234_5ABC, 2'd2, EC_PPI, 5'd7);

        tlb_set(1'b1, 6'd21, 20'h00A00, 1'b1, 1'b1, 2'd3);
        xact("ps21a", 32'h0012_3456, 1'b0, 1'b0, 32'h00B2_3456, 2'd2, EC_NONE, 5'd7);
        tlb_set(1'b1, 6'd21, 20'h01400, 1'b1, 1'b1, 2'd3);
        xact("ps21b", 32'h0012_3456, 1'b0, 1'b0, 32'h0152_3456, 2'd2, EC_NONE, 5'd7);

        // Stall: accepted response must hold while req_valid stays high.
        tlb_set(1'b1, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd3);
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b1; req_vaddr = 32'h0040_2ABC;
        req_fetch = 1'b0; req_store = 1'b0;
        @(posedge clk);
        #1;
        req_vaddr = 32'h1111_1000; csr_plv = 2'd0; csr_da = 1'b1; csr_pg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall/valid", 32'(resp_valid), 32'd1);
            check("stall/ready", 32'(req_ready), 32'd0);
            check("stall/s_fetch", 32'(s_fetch), 32'd0);
            check("stall/paddr", resp_paddr, 32'h1234_5ABC);
            check("stall/ecode", 32'(resp_ecode), 32'(EC_NONE));
            check("stall/idx", 32'(resp_tlb_idx), 32'd7);
            $display("stall cycle %0d pa=%08h ready=%0d", i, resp_paddr, req_ready);
            @(posedge clk);
            #1;
        end
        flush = 1'b1; resp_ready = 1'b1;
        #1;
        check("flush/s_fetch", 32'(s_fetch), 32'd0);
        @(posedge clk);
        #1;
        check("flush/valid", 32'(resp_valid), 32'd0);
        $display("flush resp_valid=%0d", resp_valid);
        flush = 1'b0; req_valid = 1'b0;

        // Reset in the middle of a stall.
        csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd3;
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b1; req_vaddr = 32'h0040_2ABC;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rststall/valid1", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1;
        check("rststall/valid2", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst/valid", 32'(resp_valid), 32'd0);
        check("rst/paddr", resp_paddr, 32'd0);
        $display("reset mid-stall resp_valid=%0d", resp_valid);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
